// File: rtl/mux_nx1_pipe_if.sv
// Streaming handshake bundle for the pipelined N:1 multiplexer.
// The slave view is the mux itself; the master view is the producer/consumer side.
interface mux_nx1_pipe_if #(
    parameter int N_CH = 7,
    parameter int W    = 1,
    parameter int SW   = $clog2(N_CH)
);
    logic [N_CH*W-1:0] in_data;
    logic [SW-1:0]     in_sel;
    logic              in_valid;
    logic              in_ready;
    logic [W-1:0]      out_data;
    logic              out_err;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output in_data, in_sel, in_valid, out_ready,
        input  in_ready, out_data, out_err, out_valid
    );

    modport slave (
        input  in_data, in_sel, in_valid, out_ready,
        output in_ready, out_data, out_err, out_valid
    );
endinterface

// File: rtl/mux_nx1_pipe.sv
// Parametrised N-channel pipelined binary mux tree with valid/ready flow control.
// Level j is steered by select bit j; a register stage closes every PIPE_EVERY levels.
module mux_nx1_pipe #(
    parameter int N_CH       = 7,
    parameter int W          = 1,
    parameter int PIPE_EVERY = 1
) (
    input  logic            clk,
    input  logic            rst,
    mux_nx1_pipe_if.slave   bus
);
    localparam int SW     = $clog2(N_CH);
    localparam int LEVELS = SW;
    localparam int NP     = 1 << SW;

    logic         w_adv;
    logic         w_err_in;

    // Per-level views: what enters the level, the 2:1 results, and what leaves it
    // (either the mux results directly or the stage register that closes the level).
    logic [W-1:0]  w_din  [LEVELS][NP];
    logic [W-1:0]  w_dmux [LEVELS][NP];
    logic [W-1:0]  w_dout [LEVELS][NP];
    logic [SW-1:0] w_sin  [LEVELS];
    logic [SW-1:0] w_sout [LEVELS];
    logic          w_vin  [LEVELS];
    logic          w_vout [LEVELS];
    logic          w_ein  [LEVELS];
    logic          w_eout [LEVELS];

    assign w_adv        = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = w_adv;
    assign w_err_in     = ({1'b0, bus.in_sel} >= (SW+1)'(N_CH));

    generate
        for (genvar gi = 0; gi < LEVELS; gi++) begin : gen_lvl
            localparam bit STAGE_END = ((gi % PIPE_EVERY) == (PIPE_EVERY - 1)) || (gi == LEVELS - 1);
            localparam bit LAST      = (gi == LEVELS - 1);

            if (gi == 0) begin : gen_src_in
                for (genvar gj = 0; gj < NP; gj++) begin : gen_leaf
                    if (gj < N_CH) begin : gen_used
                        assign w_din[0][gj] = bus.in_data[gj*W +: W];
                    end else begin : gen_pad
                        assign w_din[0][gj] = '0;
                    end
                end
                assign w_sin[0] = bus.in_sel;
                assign w_vin[0] = bus.in_valid;
                assign w_ein[0] = w_err_in;
            end else begin : gen_src_prev
                for (genvar gj = 0; gj < NP; gj++) begin : gen_pass
                    assign w_din[gi][gj] = w_dout[gi-1][gj];
                end
                assign w_sin[gi] = w_sout[gi-1];
                assign w_vin[gi] = w_vout[gi-1];
                assign w_ein[gi] = w_eout[gi-1];
            end

            for (genvar gj = 0; gj < NP/2; gj++) begin : gen_mux
                assign w_dmux[gi][gj] = w_sin[gi][gi] ? w_din[gi][2*gj+1] : w_din[gi][2*gj];
            end
            for (genvar gj = NP/2; gj < NP; gj++) begin : gen_zero
                assign w_dmux[gi][gj] = '0;
            end

            if (STAGE_END) begin : gen_reg
                logic [W-1:0] r_data [NP];
                logic         r_valid;
                logic         r_err;

                // Payload only loads on real beats so bubbles never disturb held values.
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        for (int k = 0; k < NP; k++) r_data[k] <= '0;
                        r_valid <= 1'b0;
                        r_err   <= 1'b0;
                    end else if (w_adv) begin
                        r_valid <= w_vin[gi];
                        if (w_vin[gi]) begin
                            for (int k = 0; k < NP; k++)
                                r_data[k] <= (LAST && w_ein[gi]) ? '0 : w_dmux[gi][k];
                            r_err <= w_ein[gi];
                        end
                    end
                end

                for (genvar gj = 0; gj < NP; gj++) begin : gen_q
                    assign w_dout[gi][gj] = r_data[gj];
                end
                assign w_vout[gi] = r_valid;
                assign w_eout[gi] = r_err;

                if (!LAST) begin : gen_sel
                    logic [SW-1:0] r_sel;
                    always_ff @(posedge clk or posedge rst) begin
                        if (rst)
                            r_sel <= '0;
                        else if (w_adv && w_vin[gi])
                            r_sel <= w_sin[gi];
                    end
                    assign w_sout[gi] = r_sel;
                end else begin : gen_sel_end
                    assign w_sout[gi] = w_sin[gi];
                end
            end else begin : gen_comb
                for (genvar gj = 0; gj < NP; gj++) begin : gen_q
                    assign w_dout[gi][gj] = w_dmux[gi][gj];
                end
                assign w_sout[gi] = w_sin[gi];
                assign w_vout[gi] = w_vin[gi];
                assign w_eout[gi] = w_ein[gi];
            end
        end
    endgenerate

    assign bus.out_data  = w_dout[LEVELS-1][0];
    assign bus.out_err   = w_eout[LEVELS-1];
    assign bus.out_valid = w_vout[LEVELS-1];
endmodule

// File: tb/tb_mux_nx1_pipe.sv
// Directed bench for mux_nx1_pipe: defaults (7x1, LAT=3) and a 12x8 PIPE_EVERY=2 (LAT=2) instance.
module tb_mux_nx1_pipe;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mux_nx1_pipe_if #(.N_CH(7),  .W(1)) if_a ();
    mux_nx1_pipe_if #(.N_CH(12), .W(8)) if_b ();

    mux_nx1_pipe #(.N_CH(7), .W(1), .PIPE_EVERY(1)) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (if_a)
    );

    mux_nx1_pipe #(.N_CH(12), .W(8), .PIPE_EVERY(2)) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (if_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hand-computed: channel k of 7'b1010110 is bit k.
    logic [0:0] exp_a [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [3:0] st_sel [5] = '{4'd3, 4'd7, 4'd0, 4'd11, 4'd5};
    logic [7:0] st_exp [5] = '{8'h13, 8'h17, 8'h10, 8'h1B, 8'h15};
    logic [2:0] bub_sel [4] = '{3'd1, 3'd2, 3'd3, 3'd6};
    logic [0:0] bub_exp [4] = '{1'b1, 1'b1, 1'b0, 1'b1};

    initial begin
        logic [7:0] held;
        logic       last_a;
        int n_in, n_out, stall;
        bit stall_done;

        rst = 1'b1;
        if_a.in_data = 7'b1010110; if_a.in_sel = '0; if_a.in_valid = 1'b0; if_a.out_ready = 1'b1;
        for (int k = 0; k < 12; k++) if_b.in_data[k*8 +: 8] = 8'h10 + 8'(k);
        if_b.in_sel = '0; if_b.in_valid = 1'b0; if_b.out_ready = 1'b1;
        tick(); tick();

        // Reset state
        chk("rst a out_valid", 64'(if_a.out_valid), 64'd0);
        chk("rst a out_data",  64'(if_a.out_data),  64'd0);
        chk("rst a out_err",   64'(if_a.out_err),   64'd0);
        chk("rst a in_ready",  64'(if_a.in_ready),  64'd1);
        chk("rst b out_valid", 64'(if_b.out_valid), 64'd0);
        chk("rst b out_data",  64'(if_b.out_data),  64'd0);
        #2 rst = 1'b0;
        tick();

        // Test 1: sel 0..6 back-to-back, outputs after the third edge
        for (int c = 0; c < 10; c++) begin
            if_a.in_valid = (c < 7);
            if_a.in_sel   = (c < 7) ? 3'(c) : 3'd0;
            tick();
            if (c >= 2 && c <= 8) begin
                chk($sformatf("t1 c%0d valid", c), 64'(if_a.out_valid), 64'd1);
                chk($sformatf("t1 c%0d data", c),  64'(if_a.out_data),  64'(exp_a[c-2]));
                chk($sformatf("t1 c%0d err", c),   64'(if_a.out_err),   64'd0);
            end else begin
                chk($sformatf("t1 c%0d valid", c), 64'(if_a.out_valid), 64'd0);
            end
        end

        // Test 2: out-of-range select 7
        if_a.in_valid = 1'b1; if_a.in_sel = 3'd7;
        tick();
        if_a.in_valid = 1'b0; if_a.in_sel = 3'd1;
        chk("t2 c0 valid", 64'(if_a.out_valid), 64'd0);
        tick();
        chk("t2 c1 valid", 64'(if_a.out_valid), 64'd0);
        tick();
        chk("t2 c2 valid", 64'(if_a.out_valid), 64'd1);
        chk("t2 c2 data",  64'(if_a.out_data),  64'd0);
        chk("t2 c2 err",   64'(if_a.out_err),   64'd1);
        tick();
        chk("t2 c3 valid", 64'(if_a.out_valid), 64'd0);
        chk("t2 c3 err held", 64'(if_a.out_err), 64'd1);

        // Test 3: 12x8, PIPE_EVERY=2
        if_b.in_valid = 1'b1; if_b.in_sel = 4'd11;
        tick();
        chk("t3 c0 valid", 64'(if_b.out_valid), 64'd0);
        if_b.in_sel = 4'd12;
        tick();
        if_b.in_valid = 1'b0;
        chk("t3 sel11 valid", 64'(if_b.out_valid), 64'd1);
        chk("t3 sel11 data",  64'(if_b.out_data),  64'h1B);
        chk("t3 sel11 err",   64'(if_b.out_err),   64'd0);
        tick();
        chk("t3 sel12 valid", 64'(if_b.out_valid), 64'd1);
        chk("t3 sel12 data",  64'(if_b.out_data),  64'h00);
        chk("t3 sel12 err",   64'(if_b.out_err),   64'd1);
        tick();
        chk("t3 drain valid", 64'(if_b.out_valid), 64'd0);

        // Test 4: five beats with a four-cycle stall once output is valid
        n_in = 0; n_out = 0; stall = 0; stall_done = 1'b0; held = '0;
        for (int cyc = 0; cyc < 40 && n_out < 5; cyc++) begin
            if_b.in_valid = (n_in < 5);
            if_b.in_sel   = (n_in < 5) ? st_sel[n_in] : 4'd2;
            if (!stall_done && stall == 0 && if_b.out_valid) begin
                stall = 4;
                held  = if_b.out_data;
            end
            if_b.out_ready = (stall == 0);
            #1;
            if (stall > 0) begin
                chk($sformatf("t4 stall%0d in_ready", stall), 64'(if_b.in_ready),  64'd0);
                chk($sformatf("t4 stall%0d valid", stall),    64'(if_b.out_valid), 64'd1);
                chk($sformatf("t4 stall%0d data", stall),     64'(if_b.out_data),  64'(held));
                stall--;
                if (stall == 0) stall_done = 1'b1;
            end
            if (if_b.in_valid && if_b.in_ready) n_in++;
            if (if_b.out_valid && if_b.out_ready) begin
                chk($sformatf("t4 beat%0d", n_out), 64'(if_b.out_data), 64'(st_exp[n_out]));
                n_out++;
            end
            tick();
        end
        chk("t4 beats out", 64'(n_out), 64'd5);
        chk("t4 stall seen", 64'(stall_done), 64'd1);
        if_b.in_valid = 1'b0; if_b.out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("t4 no extra c%0d", c), 64'(if_b.out_valid), 64'd0);
        end

        // Test 5: alternating bubbles on the default instance
        last_a = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if_a.in_valid = (c < 8) && (c % 2 == 0);
            if_a.in_sel   = (c < 8 && c % 2 == 0) ? bub_sel[c/2] : 3'd5;
            tick();
            if (c >= 2 && (c - 2) % 2 == 0 && (c - 2) / 2 < 4) begin
                chk($sformatf("t5 c%0d valid", c), 64'(if_a.out_valid), 64'd1);
                chk($sformatf("t5 c%0d data", c),  64'(if_a.out_data),  64'(bub_exp[(c-2)/2]));
                last_a = bub_exp[(c-2)/2];
            end else begin
                chk($sformatf("t5 c%0d valid", c), 64'(if_a.out_valid), 64'd0);
                if (c >= 3) chk($sformatf("t5 c%0d held", c), 64'(if_a.out_data), 64'(last_a));
            end
        end

        // Test 6: asynchronous reset with three beats in flight
        for (int c = 0; c < 3; c++) begin
            if_a.in_valid = 1'b1;
            if_a.in_sel   = (c == 0) ? 3'd1 : ((c == 1) ? 3'd2 : 3'd4);
            tick();
        end
        if_a.in_valid = 1'b0;
        chk("t6 pre valid", 64'(if_a.out_valid), 64'd1);
        chk("t6 pre data",  64'(if_a.out_data),  64'd1);
        #3 rst = 1'b1;
        #1;
        chk("t6 async valid", 64'(if_a.out_valid), 64'd0);
        chk("t6 async data",  64'(if_a.out_data),  64'd0);
        chk("t6 async err",   64'(if_a.out_err),   64'd0);
        #2 rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            chk($sformatf("t6 stale c%0d", c), 64'(if_a.out_valid), 64'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
